// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Sequential double-dabble binary-to-BCD converter, one bit per clk,
//            valid/ready on both sides. Optional macro: BIN2BCD_LZ_BLANK_EN
//            (adds leading-zero blank_mask output).
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int BIN_WIDTH  = 12,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BIN_WIDTH-1:0]    bin_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    overflow,
    output logic                    busy
`ifdef BIN2BCD_LZ_BLANK_EN
    ,
    output logic [NUM_DIGITS-1:0]   blank_mask
`endif
);

    localparam int c_DW = 4 * NUM_DIGITS;
    localparam int c_CW = $clog2(BIN_WIDTH);
    localparam logic [c_CW-1:0] c_CNT_INIT = c_CW'(BIN_WIDTH - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]           r_state;
    logic [BIN_WIDTH-1:0] r_shift;
    logic [c_DW-1:0]      r_digits;
    logic [c_DW-1:0]      r_bcd;
    logic [c_CW-1:0]      r_cnt;
    logic                 r_ovf;

    logic [c_DW-1:0]      w_adj;
    logic [c_DW-1:0]      w_next_digits;
    logic                 w_carry;

    generate
        for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
            assign w_adj[4*g +: 4] = (r_digits[4*g +: 4] >= 4'd5) ?
                                     r_digits[4*g +: 4] + 4'd3 :
                                     r_digits[4*g +: 4];
        end
    endgenerate

    // The bit leaving the top digit carries weight 10^NUM_DIGITS.
    assign w_carry       = w_adj[c_DW-1];
    assign w_next_digits = {w_adj[c_DW-2:0], r_shift[BIN_WIDTH-1]};

`ifdef BIN2BCD_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] w_blank;
    logic [NUM_DIGITS-1:0] r_blank;

    always_comb begin
        logic w_run;
        w_run   = 1'b1;
        w_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_run      = w_run & (w_next_digits[4*i +: 4] == 4'd0);
            w_blank[i] = w_run;
        end
    end

    assign blank_mask = r_blank;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_shift  <= '0;
            r_digits <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
`ifdef BIN2BCD_LZ_BLANK_EN
            r_blank  <= '0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_shift  <= bin_in;
                        r_digits <= '0;
                        r_ovf    <= 1'b0;
                        r_cnt    <= c_CNT_INIT;
                        r_state  <= c_SHIFT;
                    end
                end
                c_SHIFT: begin
                    r_digits <= w_next_digits;
                    r_shift  <= {r_shift[BIN_WIDTH-2:0], 1'b0};
                    if (w_carry) begin
                        r_ovf <= 1'b1;
                    end
                    if (r_cnt == '0) begin
                        // Publish straight from the final iteration so bcd_out
                        // survives into the next conversion untouched.
                        r_bcd   <= w_next_digits;
`ifdef BIN2BCD_LZ_BLANK_EN
                        r_blank <= w_blank;
`endif
                        r_state <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt - c_CW'(1);
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == c_IDLE);
    assign busy      = (r_state == c_SHIFT);
    assign out_valid = (r_state == c_DONE);
    assign bcd_out   = r_bcd;
    assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin2bcd_seq
// Purpose  : Directed self-checking bench for bin2bcd_seq (4- and 3-digit builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] bin_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] bcd_out;
    logic        overflow;
    logic        busy;

    logic        in3_valid = 1'b0;
    logic        in3_ready;
    logic [11:0] bin3_in = '0;
    logic        out3_valid;
    logic        out3_ready = 1'b0;
    logic [11:0] bcd3_out;
    logic        overflow3;
    logic        busy3;

`ifdef BIN2BCD_LZ_BLANK_EN
    logic [3:0]  blank_mask;
    logic [2:0]  blank3_mask;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_WIDTH(12), .NUM_DIGITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_in    (bin_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd_out   (bcd_out),
        .overflow  (overflow),
        .busy      (busy)
`ifdef BIN2BCD_LZ_BLANK_EN
        ,
        .blank_mask(blank_mask)
`endif
    );

    bin2bcd_seq #(.BIN_WIDTH(12), .NUM_DIGITS(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in3_valid),
        .in_ready  (in3_ready),
        .bin_in    (bin3_in),
        .out_valid (out3_valid),
        .out_ready (out3_ready),
        .bcd_out   (bcd3_out),
        .overflow  (overflow3),
        .busy      (busy3)
`ifdef BIN2BCD_LZ_BLANK_EN
        ,
        .blank_mask(blank3_mask)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Full conversion on the 4-digit unit; optionally stalls the consumer and
    // keeps in_valid asserted with unrelated data while the unit is busy.
    task automatic run_conv(input string tag, input logic [11:0] v, input logic [15:0] exp_bcd,
                            input logic exp_ovf, input logic [3:0] exp_blank,
                            input int hold, input bit inject);
        int cycles;
        int busy_cnt;
        in_valid = 1'b1;
        bin_in   = v;
        @(posedge clk); #1;
        in_valid = inject;
        bin_in   = ~v;
        cycles   = 0;
        busy_cnt = 0;
        while (!out_valid && cycles < 40) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            cycles++;
        end
        check({tag, "_lat"}, 32'(cycles), 32'd12);
        check({tag, "_busy"}, 32'(busy_cnt), 32'd12);
        check({tag, "_bcd"}, 32'(bcd_out), 32'(exp_bcd));
        check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
`ifdef BIN2BCD_LZ_BLANK_EN
        check({tag, "_blank"}, 32'(blank_mask), 32'(exp_blank));
`endif
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_bcd"}, 32'(bcd_out), 32'(exp_bcd));
            check({tag, "_hold_inrdy"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_drop_inrdy"}, 32'(in_ready), 32'd1);
        check({tag, "_keep_bcd"}, 32'(bcd_out), 32'(exp_bcd));
        @(posedge clk); #1;
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic run_conv3(input string tag, input logic [11:0] v, input logic [11:0] exp_bcd,
                             input logic exp_ovf, input logic [2:0] exp_blank);
        int cycles;
        in3_valid = 1'b1;
        bin3_in   = v;
        @(posedge clk); #1;
        in3_valid = 1'b0;
        cycles    = 0;
        while (!out3_valid && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        check({tag, "_lat"}, 32'(cycles), 32'd12);
        check({tag, "_bcd"}, 32'(bcd3_out), 32'(exp_bcd));
        check({tag, "_ovf"}, 32'(overflow3), 32'(exp_ovf));
`ifdef BIN2BCD_LZ_BLANK_EN
        check({tag, "_blank"}, 32'(blank3_mask), 32'(exp_blank));
`endif
        out3_ready = 1'b1;
        @(posedge clk); #1;
        out3_ready = 1'b0;
        check({tag, "_drop"}, 32'(out3_valid), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_inrdy", 32'(in_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_bcd", 32'(bcd_out), 32'd0);
`ifdef BIN2BCD_LZ_BLANK_EN
        check("rst_blank", 32'(blank_mask), 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        run_conv("v4095", 12'd4095, 16'h4095, 1'b0, 4'b0000, 0, 1'b0);
        run_conv("v0",    12'd0,    16'h0000, 1'b0, 4'b1110, 0, 1'b0);
        run_conv("v1234", 12'd1234, 16'h1234, 1'b0, 4'b0000, 5, 1'b0);
        run_conv("v42",   12'd42,   16'h0042, 1'b0, 4'b1100, 3, 1'b1);

        // Reset in the middle of converting 2748
        in_valid = 1'b1;
        bin_in   = 12'd2748;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_inrdy", 32'(in_ready), 32'd1);
        check("mid_rst_bcd", 32'(bcd_out), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
`ifdef BIN2BCD_LZ_BLANK_EN
        check("mid_rst_blank", 32'(blank_mask), 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("post_rst_valid", 32'(out_valid), 32'd0);
        check("post_rst_inrdy", 32'(in_ready), 32'd1);
        run_conv("v7", 12'd7, 16'h0007, 1'b0, 4'b1110, 0, 1'b0);

        run_conv3("d3_1000", 12'd1000, 12'h000, 1'b1, 3'b110);
        run_conv3("d3_999",  12'd999,  12'h999, 1'b0, 3'b000);
        run_conv3("d3_4095", 12'd4095, 12'h095, 1'b1, 3'b100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
